// File: rtl/pmem_write_buffer_pkg.sv
// Shared types and constants for the physical-memory write buffer.
// Optional feature macro used by the design: WB_COALESCE_EN.
package pmem_write_buffer_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned LINE_W     = 128;
    localparam int unsigned WB_TAG_MSB = 15;
    localparam int unsigned WB_TAG_LSB = 4;
    localparam int unsigned WB_TAG_W   = WB_TAG_MSB - WB_TAG_LSB + 1;

    typedef logic [ADDR_W-1:0]   lc3b_word;
    typedef logic [LINE_W-1:0]   cache_line;
    typedef logic [WB_TAG_W-1:0] wb_tag_t;

    // Upstream (L1 arbiter facing) controller states
    typedef enum logic [1:0] {
        U_IDLE   = 2'd0,
        U_RDMISS = 2'd1,
        U_RESP   = 2'd2
    } wb_ustate_t;

    // Downstream (L2 facing) controller states
    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_DRAIN = 2'd1,
        D_READ  = 2'd2
    } wb_dstate_t;

    // Line tag of a byte address
    function automatic wb_tag_t wb_tag_of(input lc3b_word addr);
        return addr[WB_TAG_MSB:WB_TAG_LSB];
    endfunction

    // Line-aligned address rebuilt from a tag
    function automatic lc3b_word wb_line_addr(input wb_tag_t tag);
        return {tag, {WB_TAG_LSB{1'b0}}};
    endfunction

endpackage

// File: rtl/pmem_write_buffer_wb_entry_array.sv
// Entry storage for the write buffer: valid/tag/data per slot, one write port,
// one invalidate port and a youngest-wins tag match scanned in FIFO age order.
module pmem_write_buffer_wb_entry_array
    import pmem_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_wr_en,
    input  logic [IDX_W-1:0]    i_wr_idx,
    input  logic [WB_TAG_W-1:0] i_wr_tag,
    input  logic [LINE_W-1:0]   i_wr_data,
    input  logic                i_clr_en,
    input  logic [IDX_W-1:0]    i_clr_idx,
    input  logic [IDX_W-1:0]    i_head_idx,
    input  logic [WB_TAG_W-1:0] i_lookup_tag,
    output logic                o_hit,
    output logic [IDX_W-1:0]    o_hit_idx,
    output logic [LINE_W-1:0]   o_hit_data,
    output logic [LINE_W-1:0]   o_head_data,
    output logic [WB_TAG_W-1:0] o_head_tag
);

    logic [DEPTH-1:0]    r_valid;
    logic [WB_TAG_W-1:0] r_tag  [DEPTH];
    logic [LINE_W-1:0]   r_data [DEPTH];
    logic [IDX_W-1:0]    w_scan_idx;

    // Valid bits and tags; a write to the same slot as an invalidate wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            if (i_clr_en) begin
                r_valid[i_clr_idx] <= 1'b0;
            end
            if (i_wr_en) begin
                r_valid[i_wr_idx] <= 1'b1;
                r_tag[i_wr_idx]   <= i_wr_tag;
            end
        end
    end

    // Line data; only ever read from slots whose valid bit is set
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    // Scan oldest to youngest from head so the last match is the youngest one
    always_comb begin
        o_hit      = 1'b0;
        o_hit_idx  = '0;
        w_scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_scan_idx = i_head_idx + k[IDX_W-1:0];
            if (r_valid[w_scan_idx] && (r_tag[w_scan_idx] == i_lookup_tag)) begin
                o_hit     = 1'b1;
                o_hit_idx = w_scan_idx;
            end
        end
    end

    assign o_hit_data  = r_data[o_hit_idx];
    assign o_head_data = r_data[i_head_idx];
    assign o_head_tag  = r_tag[i_head_idx];

endmodule

// File: rtl/pmem_write_buffer.sv
// Line write buffer between the L1 I/D arbiter and L2. Writebacks are absorbed
// in one cycle and drained to L2 in the background; reads are forwarded from
// buffered lines (youngest match) or passed to L2 as misses.
// Optional feature: define WB_COALESCE_EN to merge writes into a matching
// non-head entry instead of allocating.
// DEPTH must be a power of two and at least 2 (pointers wrap by overflow).
module pmem_write_buffer
    import pmem_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    input  logic         pmem_read,
    input  logic         pmem_write,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic [15:0]  l2_address,
    output logic [127:0] l2_wdata,
    output logic         l2_read,
    output logic         l2_write,
    input  logic [127:0] l2_rdata,
    input  logic         l2_resp,
    output logic         wb_empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_ustate_t       r_ustate;
    wb_dstate_t       r_dstate;
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             r_pmem_resp;
    logic [127:0]     r_pmem_rdata;
    logic             r_l2_read;
    logic             r_l2_write;
    logic [15:0]      r_l2_address;
    logic [127:0]     r_l2_wdata;

    logic                w_full;
    logic                w_empty;
    logic [WB_TAG_W-1:0] w_tag;
    logic                w_hit;
    logic [IDX_W-1:0]    w_hit_idx;
    logic [LINE_W-1:0]   w_hit_data;
    logic [LINE_W-1:0]   w_head_data;
    logic [WB_TAG_W-1:0] w_head_tag;
    logic                w_rd_req;
    logic                w_wr_req;
    logic                w_coalesce;
    logic                w_push;
    logic                w_pop;
    logic                w_wr_accept;
    logic                w_arr_we;
    logic [IDX_W-1:0]    w_arr_widx;
    logic                w_rd_done;
    logic                w_read_start;
    logic                w_unused_addr_lo;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_tag   = wb_tag_of(pmem_address);

    // Byte offset within the line plays no part in line-granular requests
    assign w_unused_addr_lo = ^pmem_address[WB_TAG_LSB-1:0];

    // A simultaneous read and write is treated as a read; the write is dropped
    assign w_rd_req = (r_ustate == U_IDLE) && pmem_read;
    assign w_wr_req = (r_ustate == U_IDLE) && pmem_write && !pmem_read;

`ifdef WB_COALESCE_EN
    // The head may be mid-drain with its data already on l2_wdata, so a match
    // there always allocates rather than merging.
    assign w_coalesce = w_wr_req && w_hit && (w_hit_idx != r_head);
`else
    logic w_unused_hit_idx;
    assign w_unused_hit_idx = ^w_hit_idx;
    assign w_coalesce       = 1'b0;
`endif

    assign w_push       = w_wr_req && !w_coalesce && !w_full;
    assign w_wr_accept  = w_push || w_coalesce;
    assign w_arr_we     = w_wr_accept;
    assign w_arr_widx   = w_coalesce ? w_hit_idx : r_tail;
    assign w_pop        = (r_dstate == D_DRAIN) && l2_resp;
    assign w_rd_done    = (r_dstate == D_READ) && l2_resp;
    assign w_read_start = (r_dstate == D_IDLE) && (r_ustate == U_RDMISS);

    pmem_write_buffer_wb_entry_array #(
        .DEPTH (DEPTH)
    ) u_entries (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr_en      (w_arr_we),
        .i_wr_idx     (w_arr_widx),
        .i_wr_tag     (w_tag),
        .i_wr_data    (pmem_wdata),
        .i_clr_en     (w_pop),
        .i_clr_idx    (r_head),
        .i_head_idx   (r_head),
        .i_lookup_tag (w_tag),
        .o_hit        (w_hit),
        .o_hit_idx    (w_hit_idx),
        .o_hit_data   (w_hit_data),
        .o_head_data  (w_head_data),
        .o_head_tag   (w_head_tag)
    );

    // Upstream FSM: sample one request in U_IDLE, answer with a one-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ustate     <= U_IDLE;
            r_pmem_resp  <= 1'b0;
            r_pmem_rdata <= '0;
        end else begin
            r_pmem_resp <= 1'b0;
            unique case (r_ustate)
                U_IDLE: begin
                    if (w_rd_req) begin
                        if (w_hit) begin
                            r_pmem_rdata <= w_hit_data;
                            r_pmem_resp  <= 1'b1;
                            r_ustate     <= U_RESP;
                        end else begin
                            r_ustate <= U_RDMISS;
                        end
                    end else if (w_wr_accept) begin
                        r_pmem_resp <= 1'b1;
                        r_ustate    <= U_RESP;
                    end
                end
                U_RDMISS: begin
                    if (w_rd_done) begin
                        r_pmem_rdata <= l2_rdata;
                        r_pmem_resp  <= 1'b1;
                        r_ustate     <= U_RESP;
                    end
                end
                U_RESP: begin
                    r_ustate <= U_IDLE;
                end
                default: begin
                    r_ustate <= U_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; push and pop may happen in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + IDX_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + IDX_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Downstream FSM: finish the current L2 transaction, then prefer a read miss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dstate     <= D_IDLE;
            r_l2_read    <= 1'b0;
            r_l2_write   <= 1'b0;
            r_l2_address <= '0;
            r_l2_wdata   <= '0;
        end else begin
            unique case (r_dstate)
                D_IDLE: begin
                    if (w_read_start) begin
                        r_dstate     <= D_READ;
                        r_l2_read    <= 1'b1;
                        r_l2_address <= wb_line_addr(w_tag);
                    end else if (!w_empty) begin
                        r_dstate     <= D_DRAIN;
                        r_l2_write   <= 1'b1;
                        r_l2_address <= wb_line_addr(w_head_tag);
                        r_l2_wdata   <= w_head_data;
                    end
                end
                D_DRAIN: begin
                    if (l2_resp) begin
                        r_l2_write <= 1'b0;
                        r_dstate   <= D_IDLE;
                    end
                end
                D_READ: begin
                    if (l2_resp) begin
                        r_l2_read <= 1'b0;
                        r_dstate  <= D_IDLE;
                    end
                end
                default: begin
                    r_dstate <= D_IDLE;
                end
            endcase
        end
    end

    assign pmem_resp  = r_pmem_resp;
    assign pmem_rdata = r_pmem_rdata;
    assign l2_read    = r_l2_read;
    assign l2_write   = r_l2_write;
    assign l2_address = r_l2_address;
    assign l2_wdata   = r_l2_wdata;
    assign wb_empty   = w_empty && !r_l2_write;

    // Upstream must never raise read and write together
    a_no_rd_wr : assert property (@(posedge clk) disable iff (!rst_n)
        !(pmem_read && pmem_write));

endmodule

// File: tb/tb_pmem_write_buffer.sv
// Directed bench for pmem_write_buffer with hand-computed expectations.
// Build with WB_COALESCE_EN defined to check the coalescing variant.
module tb_pmem_write_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [15:0]  l2_address;
    logic [127:0] l2_wdata;
    logic         l2_read;
    logic         l2_write;
    logic [127:0] l2_rdata;
    logic         l2_resp;
    logic         wb_empty;

    int n_vec = 0;
    int n_mis = 0;

    localparam logic [127:0] DA = {4{32'hAAAA_0001}};
    localparam logic [127:0] DB = {4{32'hBBBB_0002}};
    localparam logic [127:0] DC = {4{32'hCCCC_0003}};
    localparam logic [127:0] DD = {4{32'hDDDD_0004}};
    localparam logic [127:0] DE = {4{32'hEEEE_0005}};
    localparam logic [127:0] DF = {4{32'hFFFF_0006}};
    localparam logic [127:0] DG = {4{32'h6666_0007}};
    localparam logic [127:0] DR = {4{32'h1234_5678}};
    localparam logic [127:0] DX = {4{32'h7777_0008}};

    always #5 clk = ~clk;

    pmem_write_buffer #(
        .DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .l2_address   (l2_address),
        .l2_wdata     (l2_wdata),
        .l2_read      (l2_read),
        .l2_write     (l2_write),
        .l2_rdata     (l2_rdata),
        .l2_resp      (l2_resp),
        .wb_empty     (wb_empty)
    );

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upstream write; returns one cycle after the resp pulse with request dropped
    task automatic do_write(input string tag, input logic [15:0] a, input logic [127:0] d);
        int cyc;
        cyc          = 0;
        pmem_address = a;
        pmem_wdata   = d;
        pmem_write   = 1'b1;
        do begin
            tick();
            cyc++;
        end while (!pmem_resp && cyc < 20);
        check_eq({tag, "_resp"}, pmem_resp, 1);
        check_eq({tag, "_lat"}, cyc, 1);
        pmem_write = 1'b0;
        tick();
    endtask

    // Upstream read expected to hit in the buffer
    task automatic do_read_hit(input string tag, input logic [15:0] a, input logic [127:0] d);
        int cyc;
        cyc          = 0;
        pmem_address = a;
        pmem_read    = 1'b1;
        do begin
            tick();
            cyc++;
        end while (!pmem_resp && cyc < 20);
        check_eq({tag, "_resp"}, pmem_resp, 1);
        check_eq({tag, "_lat"}, cyc, 1);
        check_eq({tag, "_data"}, pmem_rdata, d);
        check_eq({tag, "_no_l2rd"}, l2_read, 0);
        pmem_read = 1'b0;
        tick();
    endtask

    task automatic l2_ack(input logic [127:0] rd);
        l2_rdata = rd;
        l2_resp  = 1'b1;
        tick();
        l2_resp  = 1'b0;
    endtask

    // Wait for a drain write, check it, and complete it
    task automatic drain_one(input string tag, input logic [15:0] a, input logic [127:0] d);
        int cyc;
        cyc = 0;
        while (!l2_write && cyc < 10) begin
            tick();
            cyc++;
        end
        check_eq({tag, "_l2wr"}, l2_write, 1);
        check_eq({tag, "_addr"}, l2_address, a);
        check_eq({tag, "_wdata"}, l2_wdata, d);
        l2_ack('0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst_n        = 1'b1;
        pmem_address = '0;
        pmem_wdata   = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        l2_rdata     = '0;
        l2_resp      = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_resp", pmem_resp, 0);
        check_eq("rst_rdata", pmem_rdata, 0);
        check_eq("rst_l2rd", l2_read, 0);
        check_eq("rst_l2wr", l2_write, 0);
        check_eq("rst_l2addr", l2_address, 0);
        check_eq("rst_l2wdata", l2_wdata, 0);
        check_eq("rst_empty", wb_empty, 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single writeback absorbed while L2 stalls
        do_write("wrA", 16'h1230, DA);
        check_eq("wrA_l2wr", l2_write, 1);
        check_eq("wrA_l2addr", l2_address, 16'h1230);
        check_eq("wrA_l2wdata", l2_wdata, DA);
        check_eq("wrA_busy", wb_empty, 0);
        tick();
        tick();
        check_eq("wrA_stall_l2wr", l2_write, 1);
        check_eq("wrA_stall_busy", wb_empty, 0);
        l2_ack('0);
        check_eq("wrA_done_l2wr", l2_write, 0);
        check_eq("wrA_done_empty", wb_empty, 1);

        // Forwarding from the head entry while it drains
        do_write("wrB", 16'h4000, DB);
        do_read_hit("rdB", 16'h4008, DB);
        drain_one("drB", 16'h4000, DB);
        check_eq("drB_empty", wb_empty, 1);

        // Fill, then a fifth write waits for the first pop
        do_write("f0", 16'h1000, DA);
        do_write("f1", 16'h1010, DB);
        do_write("f2", 16'h1020, DC);
        do_write("f3", 16'h1030, DD);
        check_eq("full_count", dut.r_count, 4);
        pmem_address = 16'h1040;
        pmem_wdata   = DE;
        pmem_write   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("full_hold_resp", pmem_resp, 0);
        end
        check_eq("full_head_addr", l2_address, 16'h1000);
        check_eq("full_head_data", l2_wdata, DA);
        l2_ack('0);
        check_eq("full_pop_resp", pmem_resp, 0);
        check_eq("full_pop_count", dut.r_count, 3);
        tick();
        check_eq("full_accept_resp", pmem_resp, 1);
        check_eq("full_accept_count", dut.r_count, 4);
        pmem_write = 1'b0;
        tick();
        check_eq("full_resp_pulse", pmem_resp, 0);
        drain_one("dr1", 16'h1010, DB);
        drain_one("dr2", 16'h1020, DC);
        drain_one("dr3", 16'h1030, DD);
        drain_one("dr4", 16'h1040, DE);
        check_eq("fill_empty", wb_empty, 1);

        // Read miss waits behind an in-flight drain
        do_write("wrF", 16'h5000, DF);
        pmem_address = 16'h8000;
        pmem_read    = 1'b1;
        tick();
        tick();
        check_eq("miss_wait_l2rd", l2_read, 0);
        check_eq("miss_wait_resp", pmem_resp, 0);
        drain_one("drF", 16'h5000, DF);
        check_eq("miss_after_drain_resp", pmem_resp, 0);
        cyc = 0;
        while (!l2_read && cyc < 10) begin
            tick();
            cyc++;
        end
        check_eq("miss_l2rd", l2_read, 1);
        check_eq("miss_l2addr", l2_address, 16'h8000);
        check_eq("miss_l2wr", l2_write, 0);
        l2_ack(DR);
        check_eq("miss_resp", pmem_resp, 1);
        check_eq("miss_rdata", pmem_rdata, DR);
        pmem_read = 1'b0;
        tick();
        check_eq("miss_resp_pulse", pmem_resp, 0);
        check_eq("miss_l2rd_done", l2_read, 0);

        // Duplicate tags behind an older draining entry
        do_write("wrX", 16'h3000, DX);
        do_write("wrC", 16'h2000, DC);
        do_write("wrD", 16'h2000, DD);
        do_read_hit("rdD", 16'h2000, DD);
        drain_one("drX", 16'h3000, DX);
`ifdef WB_COALESCE_EN
        check_eq("dup_count", dut.r_count, 1);
        drain_one("drD", 16'h2000, DD);
`else
        check_eq("dup_count", dut.r_count, 2);
        drain_one("drC", 16'h2000, DC);
        drain_one("drD", 16'h2000, DD);
`endif
        check_eq("dup_empty", wb_empty, 1);

        // Asynchronous reset in the middle of a drain
        do_write("wrG", 16'h6000, DG);
        check_eq("rst2_pre_l2wr", l2_write, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst2_l2wr", l2_write, 0);
        check_eq("rst2_l2addr", l2_address, 0);
        check_eq("rst2_l2wdata", l2_wdata, 0);
        check_eq("rst2_rdata", pmem_rdata, 0);
        check_eq("rst2_resp", pmem_resp, 0);
        check_eq("rst2_empty", wb_empty, 1);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check_eq("rst2_stay_l2wr", l2_write, 0);
        check_eq("rst2_stay_empty", wb_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
